reflet_mem_arbiter: RTL
=======================

Name: reflet_mem_arbiter

Overview:
Shares the single-port RAM between two requesters: port 0 is the CPU memory unit (instruction fetch, load/store, push/pop) and port 1 is a secondary master (DMA or debug probe). Uses fixed priority to port 0 with a starvation bound for port 1. Sequences each access over the fixed RAM read latency and returns data with a one-cycle acknowledge. Sits between the CPU address unit and the RAM/bus.

Parameters:
wordsize, 16, width of addresses and data words
ram_latency, 2, cycles from address presented to ram_data_in valid (legal range 1..15)
starve_limit, 4, maximum consecutive port-0 grants while port 1 is requesting

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
m0_req  input  1  port 0 access request, held until m0_ack
m0_we  input  1  port 0 write (1) / read (0)
m0_addr  input  wordsize  port 0 address
m0_wdata  input  wordsize  port 0 write data
m0_rdata  output  wordsize  port 0 read data, registered
m0_ack  output  1  port 0 completion pulse
m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack: same as port 0, for port 1
ram_addr  output  wordsize  RAM address
ram_data_out  output  wordsize  RAM write data
ram_data_in  input  wordsize  RAM read data
ram_write_en  output  1  RAM write strobe
owner  output  1  port currently granted (0/1)
busy  output  1  access in progress

Behaviour:
- Reset (reset==0 at clk edge): state IDLE; starvation counter 0; m0_rdata, m1_rdata, acks, ram_addr, ram_data_out, ram_write_en, owner and busy all 0. Reset during an access aborts it; no ack is issued.
- States: IDLE, ACCESS, RELEASE.
- IDLE: if any req is sampled high at the edge, choose the winner, latch its we/addr/wdata into internal registers, set owner, and go to ACCESS with latency counter = ram_latency. If no req is high, stay in IDLE. In IDLE, ram_addr, ram_data_out and ram_write_en are 0; busy=0; owner=0.
- Winner selection:
  - Only one req high: that port wins.
  - Both high: port 1 wins if the starvation counter == starve_limit, else port 0.
- Starvation counter:
  - +1 on each port-0 grant while m1_req is high (saturates at starve_limit).
  - Cleared on a port-1 grant, or in any IDLE cycle where m1_req is low.
- ACCESS: lasts exactly ram_latency cycles.
  - ram_addr = latched addr and ram_data_out = latched wdata for all ACCESS cycles; busy=1.
  - ram_write_en=1 only in the first ACCESS cycle and only for writes.
  - On the edge ending the last ACCESS cycle: for reads, capture ram_data_in into the owner's rdata register; go to RELEASE.
- RELEASE: one cycle.
  - Owner's ack=1; rdata valid and held until that port's next read completes. Writes leave rdata unchanged.
  - ram_write_en=0; busy=1; ram_addr still holds the latched addr.
  - Reqs are ignored in this cycle. Next state is always IDLE.
- Timing: req sampled at edge E gives ack high in cycle E+ram_latency+1. Back-to-back accesses from one port are spaced ram_latency+2 cycles apart.
- Protocol rules:
  - Requester inputs are sampled only in IDLE, so changes during ACCESS/RELEASE have no effect.
  - A req deasserted before ack still completes and still acks.
  - A req held high through RELEASE is a new request in the following IDLE.
- ack is never high on both ports in the same cycle. The non-owner's ack is always 0.
- Address and data are passed unmodified, full wordsize, with no arithmetic.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, then no reqs → all outputs 0, busy=0 for 10 cycles.
- Single port-0 read: ram_latency=2, m0_addr=0x0010, RAM returns 0xBEEF → ram_addr=0x0010 for 3 cycles; m0_ack pulses once, 3 cycles after grant edge; m0_rdata=0xBEEF; ram_write_en never 1.
- Port-1 write: m1_we=1, m1_addr=0x0200, m1_wdata=0x1234 → ram_write_en=1 for exactly one cycle with ram_addr=0x0200 and ram_data_out=0x1234; m1_ack pulses; m1_rdata unchanged; owner=1 during the access.
- Simultaneous reqs, both held continuously, starve_limit=4 → grant order 0,0,0,0,1,0,0,0,0,1; never two acks in the same cycle.
- Reset mid-access: assert reset=0 during the second ACCESS cycle of a read → no ack; state IDLE; rdata=0; next request completes normally.
- Req dropped early: m0_req pulsed for one cycle → full access still runs, m0_ack pulses once, no second access starts.

Source files
------------

// File: rtl/reflet_mem_arbiter.sv
// reflet_mem_arbiter: shares one RAM port between the CPU and a secondary master
module reflet_mem_arbiter #(
  parameter int wordsize     = 16,
  parameter int ram_latency  = 2,
  parameter int starve_limit = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [wordsize-1:0] m0_addr,
  input  logic [wordsize-1:0] m0_wdata,
  output logic [wordsize-1:0] m0_rdata,
  output logic                m0_ack,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [wordsize-1:0] m1_addr,
  input  logic [wordsize-1:0] m1_wdata,
  output logic [wordsize-1:0] m1_rdata,
  output logic                m1_ack,
  output logic [wordsize-1:0] ram_addr,
  output logic [wordsize-1:0] ram_data_out,
  input  logic [wordsize-1:0] ram_data_in,
  output logic                ram_write_en,
  output logic                owner,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;
  localparam int sw = $clog2(starve_limit + 1);
  localparam logic [sw-1:0] starve_max = sw'(starve_limit);
  state_t state_q, state_d;
  logic [3:0] lat_q, lat_d;
  logic [sw-1:0] starve_q, starve_d;
  logic owner_q, owner_d, we_q, we_d, pick1;
  logic [wordsize-1:0] addr_q, addr_d, wdata_q, wdata_d, rd0_q, rd0_d, rd1_q, rd1_d;
  // port 1 wins when alone, or when port 0 has starved it for starve_limit grants
  assign pick1 = m1_req && (!m0_req || starve_q == starve_max);
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    starve_d = starve_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd0_d    = rd0_q;
    rd1_d    = rd1_q;
    case (state_q)
      IDLE: begin
        starve_d = (!m1_req || pick1) ? '0 :
                   (m0_req && starve_q != starve_max) ? starve_q + 1'b1 : starve_q;
        if (m0_req || m1_req) begin
          state_d = ACCESS;
          lat_d   = 4'(ram_latency);
          owner_d = pick1;
          we_d    = pick1 ? m1_we : m0_we;
          addr_d  = pick1 ? m1_addr : m0_addr;
          wdata_d = pick1 ? m1_wdata : m0_wdata;
        end
      end
      ACCESS: begin
        lat_d = lat_q - 1'b1;
        if (lat_q == 4'd1) begin
          state_d = RELEASE;
          rd0_d   = (!we_q && !owner_q) ? ram_data_in : rd0_q;
          rd1_d   = (!we_q && owner_q) ? ram_data_in : rd1_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      lat_q    <= '0;
      starve_q <= '0;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd0_q    <= '0;
      rd1_q    <= '0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd0_q    <= rd0_d;
      rd1_q    <= rd1_d;
    end
  end
  assign busy         = state_q != IDLE;
  assign owner        = busy && owner_q;
  assign ram_addr     = busy ? addr_q : '0;
  assign ram_data_out = busy ? wdata_q : '0;
  assign ram_write_en = state_q == ACCESS && lat_q == 4'(ram_latency) && we_q;
  assign m0_ack       = state_q == RELEASE && !owner_q;
  assign m1_ack       = state_q == RELEASE && owner_q;
  assign m0_rdata     = rd0_q;
  assign m1_rdata     = rd1_q;
endmodule
